// File: rtl/collision_pkg.sv
// Shared types for the collision arbiter: hit-type codes, per-object modes
// and the event-reporting FSM states.
package collision_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [2:0] {
    NO_HIT = 3'd0,
    LIFE   = 3'd1,
    COIN   = 3'd2,
    GOOD   = 3'd3,
    BAD    = 3'd4
  } hit_t;

  typedef enum logic [MODE_W-1:0] {
    MODE_BAD   = 3'd0,
    MODE_GOOD  = 3'd1,
    MODE_LIFE  = 3'd2,
    MODE_COIN  = 3'd3,
    MODE_SPLIT = 3'd4
  } mode_t;

  typedef enum logic {
    ST_IDLE,
    ST_REPORT
  } state_t;

  // Split objects resolve to GOOD or BAD from the caller's bad flag.
  function automatic hit_t mode_class(input mode_t mode, input logic bad);
    hit_t cls;
    case (mode)
      MODE_LIFE:  cls = LIFE;
      MODE_COIN:  cls = COIN;
      MODE_GOOD:  cls = GOOD;
      MODE_SPLIT: cls = bad ? BAD : GOOD;
      default:    cls = BAD;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/collision_pixel_classifier.sv
// Combinational per-pixel collision detect and classification for every
// object layer, including the feet-band test for split objects.
module collision_pixel_classifier
  import collision_pkg::*;
#(
  parameter int                          NUM_OBJ   = 7,
  parameter int                          Y_W       = 11,
  parameter int                          FEET_BAND = 8,
  parameter logic [NUM_OBJ*MODE_W-1:0]   OBJ_MODE  = '0
) (
  input  logic               drawing_request_player,
  input  logic [NUM_OBJ-1:0] drawing_request_obj,
  input  logic [Y_W-1:0]     pixelY,
  input  logic [Y_W-1:0]     player_bottom_y,
  output logic [NUM_OBJ-1:0] hit,
  output logic [NUM_OBJ-1:0] bad,
  output hit_t               pixel_class [NUM_OBJ]
);

  localparam logic signed [Y_W:0] BAND_S = (Y_W+1)'(FEET_BAND);

  logic signed [Y_W:0] y_s;
  logic signed [Y_W:0] bottom_s;
  logic signed [Y_W:0] band_top_s;
  logic                in_feet;

  // One extra sign bit keeps the band top negative when the player sits
  // near the top of the screen, instead of wrapping to a huge value.
  always_comb begin
    y_s        = $signed({1'b0, pixelY});
    bottom_s   = $signed({1'b0, player_bottom_y});
    band_top_s = bottom_s - BAND_S;
    in_feet    = (y_s > band_top_s) && (y_s <= bottom_s);
  end

  for (genvar i = 0; i < NUM_OBJ; i++) begin : g_obj
    assign pixel_class[i] = mode_class(mode_t'(OBJ_MODE[i*MODE_W +: MODE_W]), !in_feet);
    assign hit[i]         = drawing_request_player && drawing_request_obj[i];
    assign bad[i]         = hit[i] && (pixel_class[i] == BAD);
  end

endmodule

// File: rtl/collision_arbiter.sv
// Per-frame collision accumulation and once-per-frame event reporting over a
// valid/ready interface, plus a registered live per-pixel hit type.
module collision_arbiter
  import collision_pkg::*;
#(
  parameter int                        NUM_OBJ   = 7,
  parameter int                        Y_W       = 11,
  parameter logic [NUM_OBJ*MODE_W-1:0] OBJ_MODE  = {NUM_OBJ{MODE_BAD}},
  parameter int                        FEET_BAND = 8,
  localparam int                       OBJ_W     = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               drawing_request_player,
  input  logic [NUM_OBJ-1:0] drawing_request_obj,
  input  logic [Y_W-1:0]     pixelY,
  input  logic [Y_W-1:0]     player_bottom_y,
  input  logic               frame_end,
  output logic               event_valid,
  input  logic               event_ready,
  output logic [2:0]         event_type,
  output logic [OBJ_W-1:0]   event_obj,
  output logic               overrun,
  output logic [2:0]         hit_type_live
);

  logic [NUM_OBJ-1:0] cur_hit, cur_bad;
  hit_t               pixel_class [NUM_OBJ];
  logic [NUM_OBJ-1:0] acc_hit, acc_bad;
  logic [NUM_OBJ-1:0] pend_hit, pend_bad;
  logic [NUM_OBJ-1:0] pend_hit_nxt, pend_bad_nxt;
  logic [OBJ_W-1:0]   next_idx;
  hit_t               next_type;
  hit_t               live_nxt;
  logic               drop;
  state_t             state;

  collision_pixel_classifier #(
    .NUM_OBJ   (NUM_OBJ),
    .Y_W       (Y_W),
    .FEET_BAND (FEET_BAND),
    .OBJ_MODE  (OBJ_MODE)
  ) u_classifier (
    .drawing_request_player (drawing_request_player),
    .drawing_request_obj    (drawing_request_obj),
    .pixelY                 (pixelY),
    .player_bottom_y        (player_bottom_y),
    .hit                    (cur_hit),
    .bad                    (cur_bad),
    .pixel_class            (pixel_class)
  );

  // NOTE: every variable gets a default before any conditional assignment,
  // otherwise an unassigned path infers a latch.
  always_comb begin
    live_nxt = NO_HIT;
    for (int i = NUM_OBJ-1; i >= 0; i--)
      if (cur_hit[i]) live_nxt = pixel_class[i];
  end

  // Next pending set: retire the accepted event first, so a handshake in the
  // frame_end cycle counts as delivered rather than dropped.
  always_comb begin
    pend_hit_nxt = pend_hit;
    pend_bad_nxt = pend_bad;
    drop         = 1'b0;
    if (event_valid && event_ready) pend_hit_nxt[event_obj] = 1'b0;
    if (frame_end) begin
      drop         = (state == ST_REPORT) && (pend_hit_nxt != '0);
      pend_hit_nxt = acc_hit | cur_hit;
      pend_bad_nxt = acc_bad | cur_bad;
    end
    next_idx  = '0;
    next_type = NO_HIT;
    for (int i = NUM_OBJ-1; i >= 0; i--)
      if (pend_hit_nxt[i]) begin
        next_idx  = OBJ_W'(i);
        next_type = mode_class(mode_t'(OBJ_MODE[i*MODE_W +: MODE_W]), pend_bad_nxt[i]);
      end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      acc_hit       <= '0;
      acc_bad       <= '0;
      pend_hit      <= '0;
      pend_bad      <= '0;
      event_valid   <= 1'b0;
      event_type    <= NO_HIT;
      event_obj     <= '0;
      overrun       <= 1'b0;
      hit_type_live <= NO_HIT;
    end else begin
      hit_type_live <= live_nxt;
      acc_hit       <= frame_end ? '0 : (acc_hit | cur_hit);
      acc_bad       <= frame_end ? '0 : (acc_bad | cur_bad);
      pend_hit      <= pend_hit_nxt;
      pend_bad      <= pend_bad_nxt;
      if (drop) overrun <= 1'b1;
      case (state)
        ST_IDLE:   if (pend_hit_nxt != '0) state <= ST_REPORT;
        ST_REPORT: if (pend_hit_nxt == '0) state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
      // Outputs are registered from the next pending set, so a new event is
      // presented the cycle after its handshake with no bubble.
      event_valid <= (pend_hit_nxt != '0);
      event_obj   <= next_idx;
      event_type  <= next_type;
    end
  end

endmodule

// File: tb/tb_collision_arbiter.sv
// Directed bench for collision_arbiter: a vector table for the live per-pixel
// path, then hand-written sequences for event reporting corner cases.
module tb_collision_arbiter;
  import collision_pkg::*;

  localparam int NUM_OBJ = 7;
  localparam int Y_W     = 11;
  // obj6..obj0 = GOOD, BAD, BAD, SPLIT, COIN, GOOD, LIFE
  localparam logic [NUM_OBJ*MODE_W-1:0] TB_MODE =
    {MODE_GOOD, MODE_BAD, MODE_BAD, MODE_SPLIT, MODE_COIN, MODE_GOOD, MODE_LIFE};

  logic               clk = 1'b0;
  logic               reset;
  logic               drawing_request_player;
  logic [NUM_OBJ-1:0] drawing_request_obj;
  logic [Y_W-1:0]     pixelY;
  logic [Y_W-1:0]     player_bottom_y;
  logic               frame_end;
  logic               event_valid;
  logic               event_ready;
  logic [2:0]         event_type;
  logic [2:0]         event_obj;
  logic               overrun;
  logic [2:0]         hit_type_live;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic               player;
    logic [NUM_OBJ-1:0] obj;
    logic [Y_W-1:0]     y;
    logic [Y_W-1:0]     bottom;
    logic [2:0]         exp_live;
  } vec_t;

  vec_t vecs [17];

  collision_arbiter #(
    .NUM_OBJ   (NUM_OBJ),
    .Y_W       (Y_W),
    .OBJ_MODE  (TB_MODE),
    .FEET_BAND (8)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .drawing_request_player (drawing_request_player),
    .drawing_request_obj    (drawing_request_obj),
    .pixelY                 (pixelY),
    .player_bottom_y        (player_bottom_y),
    .frame_end              (frame_end),
    .event_valid            (event_valid),
    .event_ready            (event_ready),
    .event_type             (event_type),
    .event_obj              (event_obj),
    .overrun                (overrun),
    .hit_type_live          (hit_type_live)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic check_event(input string name, input logic v, input logic [2:0] t, input logic [2:0] o);
    check({name, ".valid"}, event_valid, v);
    if (v) begin
      check({name, ".type"}, event_type, t);
      check({name, ".obj"},  event_obj,  o);
    end
  endtask

  task automatic drive(input logic p, input logic [NUM_OBJ-1:0] o, input logic [Y_W-1:0] y, input logic fe);
    drawing_request_player = p;
    drawing_request_obj    = o;
    pixelY                 = y;
    frame_end              = fe;
  endtask

  // One colliding pixel for one cycle; outputs are sampled at the negedge.
  task automatic pixel(input logic [NUM_OBJ-1:0] o, input logic [Y_W-1:0] y);
    drive(1'b1, o, y, 1'b0);
    @(negedge clk);
    drive(1'b0, '0, 11'd100, 1'b0);
  endtask

  task automatic end_frame();
    drive(1'b0, '0, 11'd100, 1'b1);
    @(negedge clk);
    drive(1'b0, '0, 11'd100, 1'b0);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 7'h7F, 11'd100, 11'd200, 3'd0};
    vecs[1]  = '{1'b1, 7'h00, 11'd100, 11'd200, 3'd0};
    vecs[2]  = '{1'b1, 7'h04, 11'd100, 11'd200, 3'd2};
    vecs[3]  = '{1'b1, 7'h02, 11'd100, 11'd200, 3'd3};
    vecs[4]  = '{1'b1, 7'h20, 11'd100, 11'd200, 3'd4};
    vecs[5]  = '{1'b1, 7'h11, 11'd100, 11'd200, 3'd1};
    vecs[6]  = '{1'b0, 7'h11, 11'd100, 11'd200, 3'd0};
    vecs[7]  = '{1'b1, 7'h08, 11'd195, 11'd200, 3'd3};
    vecs[8]  = '{1'b1, 7'h08, 11'd150, 11'd200, 3'd4};
    vecs[9]  = '{1'b1, 7'h08, 11'd192, 11'd200, 3'd4};
    vecs[10] = '{1'b1, 7'h08, 11'd193, 11'd200, 3'd3};
    vecs[11] = '{1'b1, 7'h08, 11'd200, 11'd200, 3'd3};
    vecs[12] = '{1'b1, 7'h08, 11'd201, 11'd200, 3'd4};
    vecs[13] = '{1'b1, 7'h08, 11'd2,   11'd4,   3'd3};
    vecs[14] = '{1'b1, 7'h08, 11'd0,   11'd4,   3'd3};
    vecs[15] = '{1'b1, 7'h0C, 11'd150, 11'd200, 3'd2};
    vecs[16] = '{1'b1, 7'h40, 11'd100, 11'd200, 3'd3};

    reset           = 1'b1;
    event_ready     = 1'b0;
    player_bottom_y = 11'd200;
    drive(1'b0, '0, 11'd100, 1'b0);
    repeat (2) @(negedge clk);
    check("reset.valid",   event_valid,   1'b0);
    check("reset.overrun", overrun,       1'b0);
    check("reset.live",    hit_type_live, 3'd0);
    check("reset.type",    event_type,    3'd0);
    reset = 1'b0;

    // Live per-pixel path, one vector per cycle, no frame_end.
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].player, vecs[i].obj, vecs[i].y, 1'b0);
      player_bottom_y = vecs[i].bottom;
      @(negedge clk);
      check($sformatf("live[%0d]", i), hit_type_live, vecs[i].exp_live);
      check($sformatf("noevt[%0d]", i), event_valid, 1'b0);
    end
    drive(1'b0, '0, 11'd100, 1'b0);
    player_bottom_y = 11'd200;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    // Two objects in one frame, reported lowest index first, back to back.
    event_ready = 1'b1;
    pixel(7'h20, 11'd100);
    pixel(7'h04, 11'd100);
    end_frame();
    check_event("prio.ev0", 1'b1, 3'd2, 3'd2);
    @(negedge clk);
    check_event("prio.ev1", 1'b1, 3'd4, 3'd5);
    @(negedge clk);
    check_event("prio.done", 1'b0, 3'd0, 3'd0);

    // Split object: feet-band only is GOOD; any body pixel makes it BAD.
    pixel(7'h08, 11'd195);
    end_frame();
    check_event("split.good", 1'b1, 3'd3, 3'd3);
    @(negedge clk);
    check_event("split.good_done", 1'b0, 3'd0, 3'd0);
    pixel(7'h08, 11'd195);
    pixel(7'h08, 11'd150);
    end_frame();
    check_event("split.bad", 1'b1, 3'd4, 3'd3);
    @(negedge clk);
    check_event("split.bad_done", 1'b0, 3'd0, 3'd0);

    // Backpressure: presented event holds, then drains one per cycle.
    event_ready = 1'b0;
    pixel(7'h02, 11'd100);
    pixel(7'h10, 11'd100);
    pixel(7'h40, 11'd100);
    end_frame();
    for (int k = 0; k < 5; k++) begin
      check_event($sformatf("bp.hold%0d", k), 1'b1, 3'd3, 3'd1);
      @(negedge clk);
    end
    check_event("bp.hold5", 1'b1, 3'd3, 3'd1);
    event_ready = 1'b1;
    @(negedge clk);
    check_event("bp.ev1", 1'b1, 3'd4, 3'd4);
    @(negedge clk);
    check_event("bp.ev2", 1'b1, 3'd3, 3'd6);
    @(negedge clk);
    check_event("bp.done", 1'b0, 3'd0, 3'd0);

    // Overrun: two of three events still pending when the next frame ends.
    event_ready = 1'b0;
    pixel(7'h01, 11'd100);
    pixel(7'h04, 11'd100);
    pixel(7'h20, 11'd100);
    end_frame();
    check_event("ovr.ev0", 1'b1, 3'd1, 3'd0);
    event_ready = 1'b1;
    @(negedge clk);
    event_ready = 1'b0;
    check_event("ovr.ev1", 1'b1, 3'd2, 3'd2);
    pixel(7'h02, 11'd100);
    check_event("ovr.hold", 1'b1, 3'd2, 3'd2);
    check("ovr.before", overrun, 1'b0);
    end_frame();
    check("ovr.set", overrun, 1'b1);
    check_event("ovr.new", 1'b1, 3'd3, 3'd1);
    event_ready = 1'b1;
    @(negedge clk);
    check_event("ovr.done", 1'b0, 3'd0, 3'd0);
    check("ovr.sticky", overrun, 1'b1);

    // Reset in the middle of REPORT with a partly accumulated next frame.
    event_ready = 1'b0;
    pixel(7'h04, 11'd100);
    pixel(7'h20, 11'd100);
    end_frame();
    check_event("rst.pending", 1'b1, 3'd2, 3'd2);
    pixel(7'h02, 11'd100);
    drive(1'b1, 7'h01, 11'd100, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, '0, 11'd100, 1'b0);
    check("rst.valid",   event_valid,   1'b0);
    check("rst.overrun", overrun,       1'b0);
    check("rst.live",    hit_type_live, 3'd0);
    @(negedge clk);
    check("rst.valid2",  event_valid,   1'b0);
    end_frame();
    check("rst.empty_frame", event_valid, 1'b0);
    @(negedge clk);
    check("rst.empty_frame2", event_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
